// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: flush controller state encoding and default depths.
package lc3b_types;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SQUASH   = 2'd1,
    S_LU_STALL = 2'd2
  } flush_state_t;

  localparam int unsigned SQUASH_DEPTH_DEFAULT = 3;
  localparam int unsigned LU_CYCLES_DEFAULT    = 1;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter with enable and asynchronous active-low clear; sticks at 0xFFFF.
module sat_counter16 (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        en,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/pipeline_flush_controller.sv
// Control-hazard scheduler: arbitrates mem stalls, branch redirects and load-use bubbles,
// and squashes wrong-path write enables for SQUASH_DEPTH issue slots after a redirect.
module pipeline_flush_controller
  import lc3b_types::*;
#(
  parameter int unsigned SQUASH_DEPTH = SQUASH_DEPTH_DEFAULT,
  parameter int unsigned LU_CYCLES    = LU_CYCLES_DEFAULT,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic        uncond_branch,
  input  logic        load_use_hazard,
  input  logic        mem_stall,
  input  logic        load_regfile_in,
  input  logic        mem_write_in,
  input  logic        branch_enable_in,
  output logic        load_regfile_out,
  output logic        mem_write_out,
  output logic        branch_enable_out,
  output logic        pc_redirect,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        flush_busy,
  output logic [15:0] redirect_count
);

  flush_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic             redirect;
  logic             redirect_accept;
  logic             lu_accept;

  assign redirect        = (branch_taken | uncond_branch) & ~mem_stall;
  assign redirect_accept = redirect & (state != S_SQUASH);
  assign lu_accept       = load_use_hazard & ~mem_stall & (state == S_IDLE) & ~redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (!mem_stall) begin
      unique case (state)
        S_IDLE: begin
          if (redirect) begin
            state <= S_SQUASH;
            cnt   <= CNT_W'(SQUASH_DEPTH);
          end else if (lu_accept && (LU_CYCLES > 1)) begin
            state <= S_LU_STALL;
            cnt   <= CNT_W'(LU_CYCLES - 1);
          end
        end
        S_SQUASH: begin
          if (cnt == CNT_W'(1)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_LU_STALL: begin
          if (redirect) begin
            state <= S_SQUASH;
            cnt   <= CNT_W'(SQUASH_DEPTH);
          end else if (cnt == CNT_W'(1)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Reset is folded in here too so every control output is low while rst_n is held.
  always_comb begin
    load_regfile_out  = 1'b0;
    mem_write_out     = 1'b0;
    branch_enable_out = 1'b0;
    pc_redirect       = 1'b0;
    stall_if          = 1'b0;
    stall_id          = 1'b0;
    bubble_ex         = 1'b0;
    flush_busy        = 1'b0;
    if (rst_n) begin
      flush_busy = (state == S_SQUASH);
      if (mem_stall) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
      end else if (state == S_SQUASH) begin
        flush_busy = 1'b1;
      end else begin
        load_regfile_out  = load_regfile_in;
        mem_write_out     = mem_write_in;
        branch_enable_out = branch_enable_in;
        if (redirect) begin
          pc_redirect = 1'b1;
        end else if (lu_accept || (state == S_LU_STALL)) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
    end
  end

  sat_counter16 u_redirect_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (redirect_accept),
    .count (redirect_count)
  );

endmodule

// File: tb/tb_pipeline_flush_controller.sv
// Directed self-checking bench for pipeline_flush_controller (default and LU_CYCLES=2 builds).
module tb_pipeline_flush_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic branch_taken = 1'b0, uncond_branch = 1'b0, load_use_hazard = 1'b0, mem_stall = 1'b0;
  logic load_regfile_in = 1'b1, mem_write_in = 1'b1, branch_enable_in = 1'b1;

  logic        d0_lr, d0_mw, d0_be, d0_pc, d0_sif, d0_sid, d0_bex, d0_fb;
  logic        d1_lr, d1_mw, d1_be, d1_pc, d1_sif, d1_sid, d1_bex, d1_fb;
  logic [15:0] d0_rc, d1_rc;
  logic [7:0]  v0, v1;

  logic        sc_clr_n = 1'b0, sc_en = 1'b0;
  logic [15:0] sc_count;

  int unsigned tests = 0, failed = 0;
  logic [15:0] rc_exp = '0;

  // Bit order: pc_redirect, stall_if, stall_id, bubble_ex, flush_busy, lr, mw, be
  assign v0 = {d0_pc, d0_sif, d0_sid, d0_bex, d0_fb, d0_lr, d0_mw, d0_be};
  assign v1 = {d1_pc, d1_sif, d1_sid, d1_bex, d1_fb, d1_lr, d1_mw, d1_be};

  always #5 clk = ~clk;

  pipeline_flush_controller u_dut (
    .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .uncond_branch(uncond_branch),
    .load_use_hazard(load_use_hazard), .mem_stall(mem_stall),
    .load_regfile_in(load_regfile_in), .mem_write_in(mem_write_in), .branch_enable_in(branch_enable_in),
    .load_regfile_out(d0_lr), .mem_write_out(d0_mw), .branch_enable_out(d0_be),
    .pc_redirect(d0_pc), .stall_if(d0_sif), .stall_id(d0_sid), .bubble_ex(d0_bex),
    .flush_busy(d0_fb), .redirect_count(d0_rc)
  );

  pipeline_flush_controller #(.LU_CYCLES(2)) u_dut_lu2 (
    .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .uncond_branch(uncond_branch),
    .load_use_hazard(load_use_hazard), .mem_stall(mem_stall),
    .load_regfile_in(load_regfile_in), .mem_write_in(mem_write_in), .branch_enable_in(branch_enable_in),
    .load_regfile_out(d1_lr), .mem_write_out(d1_mw), .branch_enable_out(d1_be),
    .pc_redirect(d1_pc), .stall_if(d1_sif), .stall_id(d1_sid), .bubble_ex(d1_bex),
    .flush_busy(d1_fb), .redirect_count(d1_rc)
  );

  sat_counter16 u_sat (.clk(clk), .clr_n(sc_clr_n), .en(sc_en), .count(sc_count));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    branch_taken = 1'b1; load_use_hazard = 1'b1;
    #2;
    tests++; if (v0 !== 8'b0000_0000) begin failed++; $display("FAIL reset_outs: got %b expected %b", v0, 8'b0); end
    tests++; if (v1 !== 8'b0000_0000) begin failed++; $display("FAIL reset_outs_lu2: got %b expected %b", v1, 8'b0); end
    tests++; if (d0_rc !== 16'h0000) begin failed++; $display("FAIL reset_count: got %h expected 0000", d0_rc); end
    @(negedge clk);
    rst_n = 1'b1; branch_taken = 1'b0; load_use_hazard = 1'b0;
    tick; #1;
    tests++; if (v0 !== 8'b0000_0111) begin failed++; $display("FAIL reset_release_pass: got %b expected %b", v0, 8'b0000_0111); end
  endtask

  task automatic test_branch_squash;
    tick; branch_taken = 1'b1; #1;
    tests++; if (v0 !== 8'b1000_0111) begin failed++; $display("FAIL branch_redirect: got %b expected %b", v0, 8'b1000_0111); end
    rc_exp++;
    tick; branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (v0 !== 8'b0000_1000) begin failed++; $display("FAIL squash_slot%0d: got %b expected %b", i + 1, v0, 8'b0000_1000); end
      tick;
    end
    #1;
    tests++; if (v0 !== 8'b0000_0111) begin failed++; $display("FAIL squash_exit: got %b expected %b", v0, 8'b0000_0111); end
    tests++; if (d0_rc !== rc_exp) begin failed++; $display("FAIL branch_count: got %h expected %h", d0_rc, rc_exp); end
  endtask

  task automatic test_mem_stall;
    tick; branch_taken = 1'b1; mem_stall = 1'b1; #1;
    tests++; if (v0 !== 8'b0110_0000) begin failed++; $display("FAIL idle_stall: got %b expected %b", v0, 8'b0110_0000); end
    tick; mem_stall = 1'b0; #1;
    tests++; if (d0_rc !== rc_exp) begin failed++; $display("FAIL stall_no_count: got %h expected %h", d0_rc, rc_exp); end
    tests++; if (v0 !== 8'b1000_0111) begin failed++; $display("FAIL stall_then_redirect: got %b expected %b", v0, 8'b1000_0111); end
    rc_exp++;
    tick; branch_taken = 1'b0; #1;
    tests++; if (v0 !== 8'b0000_1000) begin failed++; $display("FAIL stall_slot1: got %b expected %b", v0, 8'b0000_1000); end
    for (int i = 0; i < 2; i++) begin
      tick; mem_stall = 1'b1; #1;
      tests++; if (v0 !== 8'b0110_1000) begin failed++; $display("FAIL squash_frozen%0d: got %b expected %b", i, v0, 8'b0110_1000); end
    end
    for (int i = 0; i < 2; i++) begin
      tick; mem_stall = 1'b0; #1;
      tests++; if (v0 !== 8'b0000_1000) begin failed++; $display("FAIL stall_slot%0d: got %b expected %b", i + 2, v0, 8'b0000_1000); end
    end
    tick; #1;
    tests++; if (v0 !== 8'b0000_0111) begin failed++; $display("FAIL stall_squash_exit: got %b expected %b", v0, 8'b0000_0111); end
    tests++; if (d0_rc !== rc_exp) begin failed++; $display("FAIL stall_count: got %h expected %h", d0_rc, rc_exp); end
  endtask

  task automatic test_lu_uncond;
    tick; load_use_hazard = 1'b1; uncond_branch = 1'b1; #1;
    tests++; if (v0 !== 8'b1000_0111) begin failed++; $display("FAIL lu_uncond_prio: got %b expected %b", v0, 8'b1000_0111); end
    tests++; if (v1 !== 8'b1000_0111) begin failed++; $display("FAIL lu_uncond_prio_lu2: got %b expected %b", v1, 8'b1000_0111); end
    rc_exp++;
    tick; load_use_hazard = 1'b0; uncond_branch = 1'b0; #1;
    tests++; if (v0 !== 8'b0000_1000) begin failed++; $display("FAIL lu_uncond_squash: got %b expected %b", v0, 8'b0000_1000); end
    tick; tick; tick; #1;
    tests++; if (v0 !== 8'b0000_0111) begin failed++; $display("FAIL lu_uncond_exit: got %b expected %b", v0, 8'b0000_0111); end
  endtask

  task automatic test_branch_in_squash;
    tick; branch_taken = 1'b1; #1;
    rc_exp++;
    for (int i = 0; i < 3; i++) begin
      tick; #1;
      tests++; if (v0 !== 8'b0000_1000) begin failed++; $display("FAIL wrong_path_slot%0d: got %b expected %b", i + 1, v0, 8'b0000_1000); end
    end
    branch_taken = 1'b0;
    tick; #1;
    tests++; if (d0_rc !== rc_exp) begin failed++; $display("FAIL wrong_path_count: got %h expected %h", d0_rc, rc_exp); end
    tests++; if (v0 !== 8'b0000_0111) begin failed++; $display("FAIL wrong_path_exit: got %b expected %b", v0, 8'b0000_0111); end
  endtask

  task automatic test_load_use;
    tick; load_use_hazard = 1'b1; #1;
    tests++; if (v0 !== 8'b0111_0111) begin failed++; $display("FAIL lu_bubble1: got %b expected %b", v0, 8'b0111_0111); end
    tests++; if (v1 !== 8'b0111_0111) begin failed++; $display("FAIL lu2_bubble1: got %b expected %b", v1, 8'b0111_0111); end
    tick; load_use_hazard = 1'b0; #1;
    tests++; if (v0 !== 8'b0000_0111) begin failed++; $display("FAIL lu_done: got %b expected %b", v0, 8'b0000_0111); end
    tests++; if (v1 !== 8'b0111_0111) begin failed++; $display("FAIL lu2_bubble2: got %b expected %b", v1, 8'b0111_0111); end
    tick; #1;
    tests++; if (v1 !== 8'b0000_0111) begin failed++; $display("FAIL lu2_done: got %b expected %b", v1, 8'b0000_0111); end
    load_use_hazard = 1'b1;
    tick; load_use_hazard = 1'b0; branch_taken = 1'b1; #1;
    tests++; if (v1 !== 8'b1000_0111) begin failed++; $display("FAIL lu2_abort_redirect: got %b expected %b", v1, 8'b1000_0111); end
    rc_exp++;
    tick; branch_taken = 1'b0; #1;
    tests++; if (v1 !== 8'b0000_1000) begin failed++; $display("FAIL lu2_abort_squash: got %b expected %b", v1, 8'b0000_1000); end
    tests++; if (d1_rc !== rc_exp) begin failed++; $display("FAIL lu2_count: got %h expected %h", d1_rc, rc_exp); end
    tick; tick; tick; #1;
    tests++; if (v1 !== 8'b0000_0111) begin failed++; $display("FAIL lu2_abort_exit: got %b expected %b", v1, 8'b0000_0111); end
  endtask

  task automatic test_reset_mid_squash;
    tick; branch_taken = 1'b1;
    tick; branch_taken = 1'b0;
    tick; rst_n = 1'b0; #1;
    tests++; if (v0 !== 8'b0000_0000) begin failed++; $display("FAIL midreset_outs: got %b expected %b", v0, 8'b0); end
    tests++; if (d0_rc !== 16'h0000) begin failed++; $display("FAIL midreset_count: got %h expected 0000", d0_rc); end
    @(negedge clk);
    rst_n = 1'b1; rc_exp = '0;
    tick; #1;
    tests++; if (v0 !== 8'b0000_0111) begin failed++; $display("FAIL midreset_pass: got %b expected %b", v0, 8'b0000_0111); end
    tests++; if (d0_rc !== 16'h0000) begin failed++; $display("FAIL midreset_count_after: got %h expected 0000", d0_rc); end
  endtask

  task automatic test_saturation;
    tick; sc_clr_n = 1'b1; sc_en = 1'b1;
    for (int unsigned i = 0; i < 65534; i++) tick;
    tests++; if (sc_count !== 16'hFFFE) begin failed++; $display("FAIL sat_near: got %h expected fffe", sc_count); end
    tick;
    tests++; if (sc_count !== 16'hFFFF) begin failed++; $display("FAIL sat_top: got %h expected ffff", sc_count); end
    tick; tick; tick;
    tests++; if (sc_count !== 16'hFFFF) begin failed++; $display("FAIL sat_hold: got %h expected ffff", sc_count); end
    sc_clr_n = 1'b0; #1;
    tests++; if (sc_count !== 16'h0000) begin failed++; $display("FAIL sat_clear: got %h expected 0000", sc_count); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_branch_squash;
    test_mem_stall;
    test_lu_uncond;
    test_branch_in_squash;
    test_load_use;
    test_reset_mid_squash;
    test_saturation;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipeline_flush_controller.md
Name: pipeline_flush_controller

Overview:
Central control-hazard scheduler for the 5-stage LC-3b pipeline. Arbitrates between memory stalls, branch redirects and load-use hazards, and drives the per-stage stall and bubble controls. Squashes the architectural write enables of wrong-path instructions for a programmable number of issue slots after a taken or unconditional branch. Also keeps a saturating count of redirects for performance analysis.

Parameters:
SQUASH_DEPTH, 3, number of non-stalled cycles whose write enables are killed after a redirect (legal 1..7)
LU_CYCLES, 1, number of bubble cycles inserted per load-use hazard (legal 1..3)
CNT_W, 3, width of the internal squash/bubble down-counter; must hold max(SQUASH_DEPTH, LU_CYCLES)

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
branch_taken  in  1  conditional branch resolved taken in MEM
uncond_branch  in  1  JMP/JSR/TRAP resolved in MEM
load_use_hazard  in  1  ID-stage instruction depends on a load currently in EX
mem_stall  in  1  I-cache or D-cache not ready; the whole pipeline must freeze
load_regfile_in  in  1  MEM/WB regfile write enable
mem_write_in  in  1  MEM-stage data-memory write enable
branch_enable_in  in  1  MEM-stage branch enable
load_regfile_out  out  1  gated regfile write enable
mem_write_out  out  1  gated memory write enable
branch_enable_out  out  1  gated branch enable
pc_redirect  out  1  select branch target into PC this cycle
stall_if  out  1  hold PC and IF/ID latch
stall_id  out  1  hold ID/EX latch
bubble_ex  out  1  inject a NOP into ID/EX
flush_busy  out  1  high while in S_SQUASH
redirect_count  out  16  saturating count of accepted redirects

Behaviour:
- States: S_IDLE, S_SQUASH, S_LU_STALL. Down-counter cnt has width CNT_W.
- Reset (rst_n low, asynchronous):
  - state=S_IDLE, cnt=0, redirect_count=0.
  - All gated enables, pc_redirect, stall_*, bubble_ex and flush_busy are forced to 0 while rst_n is low.
- mem_stall has the highest priority in every state:
  - stall_if=stall_id=1, bubble_ex=0, pc_redirect=0.
  - Gated enables are 0; the frozen slot must not commit twice.
  - state, cnt and redirect_count hold.
- Redirect condition: redirect = (branch_taken | uncond_branch) & !mem_stall.
- S_IDLE:
  - Enables pass through unchanged.
  - On redirect: pc_redirect=1 combinationally in the same cycle; the branch itself commits. Next state S_SQUASH, cnt<=SQUASH_DEPTH, redirect_count increments, saturating at 0xFFFF.
  - Else on load_use_hazard & !mem_stall: stall_if=stall_id=bubble_ex=1 this cycle. If LU_CYCLES>1, go to S_LU_STALL with cnt<=LU_CYCLES-1; otherwise stay in S_IDLE.
  - Redirect together with load_use_hazard: redirect wins, no bubble is inserted.
- S_SQUASH:
  - flush_busy=1; all three gated enables are 0.
  - branch_taken, uncond_branch and load_use_hazard are ignored (wrong-path); pc_redirect=0.
  - Each non-stalled cycle, cnt decrements. When cnt==1 and !mem_stall, go to S_IDLE.
  - Exactly SQUASH_DEPTH non-stalled cycles are squashed.
- S_LU_STALL:
  - stall_if=stall_id=bubble_ex=1; enables pass through, since the older instructions are still valid.
  - Each non-stalled cycle, cnt decrements. At cnt==1 and !mem_stall, go to S_IDLE.
  - A redirect arriving here is taken as in S_IDLE and aborts the stall: pc_redirect=1, go to S_SQUASH.
- Reset asserted mid-squash or mid-stall returns to S_IDLE immediately. The first cycle after reset release passes enables through.
- Outputs other than the registered state, cnt and redirect_count are combinational from state and inputs; there is no added latency.

Decomposition:
- Add to lc3b_types: enum flush_state_t {S_IDLE, S_SQUASH, S_LU_STALL}, and constants SQUASH_DEPTH_DEFAULT=3, LU_CYCLES_DEFAULT=1.
- One sub-module, sat_counter16: enable, asynchronous active-low clear, saturates at 0xFFFF. It implements redirect_count.

Test Plan:
- Reset then branch_taken=1 for 1 cycle, all enables=1 -> pc_redirect=1 that cycle, enables pass that cycle; next 3 cycles all enables=0 and flush_busy=1; cycle 5 enables pass; redirect_count=1.
- Redirect followed by mem_stall=1 for 2 cycles in squash slot 2 -> squash lasts 3 non-stalled cycles (5 total), no enable ever high during stall.
- load_use_hazard=1 and uncond_branch=1 in the same cycle -> pc_redirect=1, bubble_ex=0, squash entered.
- LU_CYCLES=2, load_use_hazard pulse -> stall_if=stall_id=bubble_ex=1 for exactly 2 cycles; then a branch_taken during S_LU_STALL -> pc_redirect=1, S_SQUASH.
- branch_taken asserted during S_SQUASH -> no pc_redirect, redirect_count unchanged.
- rst_n low in squash slot 2 -> outputs 0 immediately; after release enables pass, redirect_count=0. Separately, force 65536 redirects -> redirect_count stays at 0xFFFF.
